// File: rtl/pixel_scan_scheduler_if.sv
// Sequencer-side link of the pixel scan scheduler: run strobe, pixel address
// and the sequencer status flags.
interface pixel_scan_scheduler_if;
   logic       run_sequencer;
   logic [3:0] SEL_input;
   logic       ready_flag;
   logic       measure_flag;

   // Scheduler side drives the run strobe and pixel address.
   modport master (
      output run_sequencer,
      output SEL_input,
      input  ready_flag,
      input  measure_flag
   );

   // Sequencer side answers with its status flags.
   modport slave (
      input  run_sequencer,
      input  SEL_input,
      output ready_flag,
      output measure_flag
   );
endinterface

// File: rtl/pixel_scan_scheduler.sv
// pixel_scan_scheduler: steps the PIX_V1 sequencer across a range of pixel
// SEL addresses, firing a fixed number of runs per pixel with an idle gap
// after every completed run. Watches the ready/measure handshake, times out
// a stuck sequencer and reports completion/error status to the host.
module pixel_scan_scheduler #(
   parameter int unsigned TIMEOUT_CYCLES = 64,
   parameter int unsigned GAP_WIDTH      = 10
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   start,
   input  logic                   abort,
   input  logic [3:0]             SEL_first,
   input  logic [3:0]             SEL_last,
   input  logic [7:0]             repetitions,
   input  logic [GAP_WIDTH-1:0]   inter_run_gap,
   pixel_scan_scheduler_if.master seq,
   output logic                   busy,
   output logic                   done,
   output logic                   error_flag,
   output logic [1:0]             error_code,
   output logic                   measure_pulse,
   output logic [15:0]            run_count
);

   // The finish timeout is sixteen times the acknowledge timeout.
   localparam int unsigned FinishCycles = TIMEOUT_CYCLES * 16;
   localparam int unsigned TmoWidth     = $clog2(FinishCycles);
   localparam logic [TmoWidth-1:0] AckLast = TmoWidth'(TIMEOUT_CYCLES - 1);
   localparam logic [TmoWidth-1:0] FinLast = TmoWidth'(FinishCycles - 1);

   localparam logic [1:0] ErrNone      = 2'd0;
   localparam logic [1:0] ErrConfig    = 2'd1;
   localparam logic [1:0] ErrAckTmo    = 2'd2;
   localparam logic [1:0] ErrFinishTmo = 2'd3;

   typedef enum logic [3:0] {
      StIdle,
      StCheck,
      StWaitReady,
      StFire,
      StWaitAck,
      StWaitFinish,
      StGap,
      StAdvance,
      StDone
   } state_e;

   state_e                 state_q, state_d;
   logic [3:0]             sel_q, sel_d;
   logic [7:0]             rep_q, rep_d;
   logic [3:0]             first_q, first_d;
   logic [3:0]             last_q, last_d;
   logic [7:0]             reps_q, reps_d;
   logic [GAP_WIDTH-1:0]   gap_q, gap_d;
   logic [GAP_WIDTH-1:0]   gap_cnt_q, gap_cnt_d;
   logic [TmoWidth-1:0]    tmo_q, tmo_d;
   logic [15:0]            run_count_q, run_count_d;
   logic [1:0]             err_code_q, err_code_d;
   logic                   err_flag_q, err_flag_d;
   logic                   meas_prev_q;
   logic                   mpulse_q, mpulse_d;
   logic                   fire;
   logic                   done_pulse;

   assign busy              = (state_q != StIdle);
   assign done              = done_pulse;
   assign error_flag        = err_flag_q;
   assign error_code        = err_code_q;
   assign measure_pulse     = mpulse_q;
   assign run_count         = run_count_q;
   assign seq.SEL_input     = sel_q;
   assign seq.run_sequencer = fire;

   // Rising edge of measure_flag, only reported while a scan is in progress.
   assign mpulse_d = seq.measure_flag & ~meas_prev_q & busy;

   // Next-state and datapath updates; abort overrides everything at the end.
   always_comb begin
      state_d     = state_q;
      sel_d       = sel_q;
      rep_d       = rep_q;
      first_d     = first_q;
      last_d      = last_q;
      reps_d      = reps_q;
      gap_d       = gap_q;
      gap_cnt_d   = gap_cnt_q;
      tmo_d       = tmo_q;
      run_count_d = run_count_q;
      err_code_d  = err_code_q;
      err_flag_d  = err_flag_q;
      fire        = 1'b0;
      done_pulse  = 1'b0;

      unique case (state_q)
         StIdle: begin
            if (start) begin
               first_d     = SEL_first;
               last_d      = SEL_last;
               reps_d      = repetitions;
               gap_d       = inter_run_gap;
               err_code_d  = ErrNone;
               err_flag_d  = 1'b0;
               run_count_d = '0;
               state_d     = StCheck;
            end
         end

         StCheck: begin
            if ((first_q > last_q) || (reps_q == 8'd0)) begin
               err_code_d = ErrConfig;
               state_d    = StDone;
            end else begin
               sel_d   = first_q;
               rep_d   = '0;
               state_d = StWaitReady;
            end
         end

         StWaitReady: begin
            if (seq.ready_flag) begin
               state_d = StFire;
            end
         end

         StFire: begin
            fire    = 1'b1;
            tmo_d   = '0;
            state_d = StWaitAck;
         end

         StWaitAck: begin
            if (!seq.ready_flag) begin
               tmo_d   = '0;
               state_d = StWaitFinish;
            end else if (tmo_q == AckLast) begin
               err_code_d = ErrAckTmo;
               state_d    = StDone;
            end else begin
               tmo_d = tmo_q + 1'b1;
            end
         end

         StWaitFinish: begin
            if (seq.ready_flag) begin
               if (run_count_q != 16'hFFFF) begin
                  run_count_d = run_count_q + 16'd1;
               end
               gap_cnt_d = '0;
               state_d   = (gap_q == '0) ? StAdvance : StGap;
            end else if (tmo_q == FinLast) begin
               err_code_d = ErrFinishTmo;
               state_d    = StDone;
            end else begin
               tmo_d = tmo_q + 1'b1;
            end
         end

         StGap: begin
            if (gap_cnt_q == gap_q - GAP_WIDTH'(1)) begin
               state_d = StAdvance;
            end else begin
               gap_cnt_d = gap_cnt_q + GAP_WIDTH'(1);
            end
         end

         StAdvance: begin
            // reps_q is non-zero here, CHECK rejected zero.
            if (rep_q < reps_q - 8'd1) begin
               rep_d   = rep_q + 8'd1;
               state_d = StWaitReady;
            end else if (sel_q == last_q) begin
               state_d = StDone;
            end else begin
               sel_d   = sel_q + 4'd1;
               rep_d   = '0;
               state_d = StWaitReady;
            end
         end

         StDone: begin
            done_pulse = 1'b1;
            if (err_code_q != ErrNone) begin
               err_flag_d = 1'b1;
            end
            state_d = StIdle;
         end

         default: begin
            state_d = StIdle;
         end
      endcase

      // Abort freezes all status and returns to idle without a done pulse;
      // in idle it also masks a simultaneous start.
      if (abort) begin
         state_d     = StIdle;
         sel_d       = sel_q;
         rep_d       = rep_q;
         first_d     = first_q;
         last_d      = last_q;
         reps_d      = reps_q;
         gap_d       = gap_q;
         gap_cnt_d   = gap_cnt_q;
         tmo_d       = tmo_q;
         run_count_d = run_count_q;
         err_code_d  = err_code_q;
         err_flag_d  = err_flag_q;
         fire        = 1'b0;
         done_pulse  = 1'b0;
      end
   end

   // State and datapath registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= StIdle;
         sel_q       <= '0;
         rep_q       <= '0;
         first_q     <= '0;
         last_q      <= '0;
         reps_q      <= '0;
         gap_q       <= '0;
         gap_cnt_q   <= '0;
         tmo_q       <= '0;
         run_count_q <= '0;
         err_code_q  <= ErrNone;
         err_flag_q  <= 1'b0;
         meas_prev_q <= 1'b0;
         mpulse_q    <= 1'b0;
      end else begin
         state_q     <= state_d;
         sel_q       <= sel_d;
         rep_q       <= rep_d;
         first_q     <= first_d;
         last_q      <= last_d;
         reps_q      <= reps_d;
         gap_q       <= gap_d;
         gap_cnt_q   <= gap_cnt_d;
         tmo_q       <= tmo_d;
         run_count_q <= run_count_d;
         err_code_q  <= err_code_d;
         err_flag_q  <= err_flag_d;
         meas_prev_q <= seq.measure_flag;
         mpulse_q    <= mpulse_d;
      end
   end

endmodule

// File: tb/tb_pixel_scan_scheduler.sv
// Bench for pixel_scan_scheduler: a behavioural sequencer answers every run,
// and each scan is compared against the list of pixel addresses the scan
// rules produce for its configuration.
module tb_pixel_scan_scheduler;
   localparam int unsigned TIMEOUT_CYCLES = 64;
   localparam int unsigned GAP_WIDTH      = 10;

   logic                 clk = 1'b0;
   logic                 reset;
   logic                 start;
   logic                 abort;
   logic [3:0]           SEL_first;
   logic [3:0]           SEL_last;
   logic [7:0]           repetitions;
   logic [GAP_WIDTH-1:0] inter_run_gap;
   logic                 busy;
   logic                 done;
   logic                 error_flag;
   logic [1:0]           error_code;
   logic                 measure_pulse;
   logic [15:0]          run_count;

   pixel_scan_scheduler_if seq_if ();

   pixel_scan_scheduler #(
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
      .GAP_WIDTH      (GAP_WIDTH)
   ) dut (
      .clk           (clk),
      .reset         (reset),
      .start         (start),
      .abort         (abort),
      .SEL_first     (SEL_first),
      .SEL_last      (SEL_last),
      .repetitions   (repetitions),
      .inter_run_gap (inter_run_gap),
      .seq           (seq_if),
      .busy          (busy),
      .done          (done),
      .error_flag    (error_flag),
      .error_code    (error_code),
      .measure_pulse (measure_pulse),
      .run_count     (run_count)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   task automatic check_eq(input string tag, input int unsigned got, input int unsigned exp);
      checks++;
      if (got != exp) begin
         errors++;
         $display("FAIL %s got %0d expected %0d", tag, got, exp);
      end
   endtask

   // Sequencer model state.
   int seq_phase  = 0;
   int ack_left   = 0;
   int fin_left   = 0;
   int ack_dly    = 0;
   int meas_time  = 10;
   bit seq_hold   = 1'b0;

   // Monitor logs.
   int fire_sel[$];
   int done_cnt      = 0;
   int mp_cnt        = 0;
   int cyc           = 0;
   int last_fire_cyc = 0;
   int last_done_cyc = 0;
   int ready_hi      = 0;
   int exp_gap       = 0;
   int prev_sel      = 0;

   // Monitor first (sees what the DUT saw at the last edge), then the
   // sequencer model updates its flags for the next edge.
   always @(negedge clk) begin
      cyc++;
      if (seq_if.ready_flag) ready_hi++;
      else ready_hi = 0;
      if (seq_if.run_sequencer) begin
         if (fire_sel.size() > 0) begin
            check_eq("fire_spacing_ge4", int'((cyc - last_fire_cyc) >= 4), 1);
            check_eq("ready_idle_ge_gap", int'(ready_hi >= exp_gap), 1);
         end
         check_eq("sel_stable_before_fire", seq_if.SEL_input, prev_sel);
         fire_sel.push_back(int'(seq_if.SEL_input));
         last_fire_cyc = cyc;
      end
      prev_sel = int'(seq_if.SEL_input);
      if (done) begin
         done_cnt++;
         last_done_cyc = cyc;
      end
      if (measure_pulse) mp_cnt++;

      seq_if.measure_flag = 1'b0;
      if (seq_phase == 0 && seq_if.run_sequencer && !seq_hold) begin
         seq_phase = 1;
         ack_left  = ack_dly;
      end
      if (seq_phase == 1) begin
         if (ack_left == 0) begin
            seq_if.ready_flag = 1'b0;
            seq_phase = 2;
            fin_left  = meas_time;
         end else begin
            ack_left--;
         end
      end else if (seq_phase == 2) begin
         fin_left--;
         if (fin_left == meas_time / 2) seq_if.measure_flag = 1'b1;
         if (fin_left == 0) begin
            seq_if.ready_flag = 1'b1;
            seq_phase = 0;
         end
      end
   end

   task automatic tick();
      @(negedge clk);
      #1;
   endtask

   task automatic check_outputs_zero(input string tag);
      check_eq({tag, ":run_sequencer"}, seq_if.run_sequencer, 0);
      check_eq({tag, ":SEL_input"}, seq_if.SEL_input, 0);
      check_eq({tag, ":busy"}, busy, 0);
      check_eq({tag, ":done"}, done, 0);
      check_eq({tag, ":error_flag"}, error_flag, 0);
      check_eq({tag, ":error_code"}, error_code, 0);
      check_eq({tag, ":measure_pulse"}, measure_pulse, 0);
      check_eq({tag, ":run_count"}, run_count, 0);
   endtask

   // Clear logs, present a configuration, pulse start, then scramble the
   // configuration inputs so only latched values can matter.
   task automatic begin_scan(input int first, input int last, input int reps, input int gap);
      fire_sel.delete();
      done_cnt      = 0;
      mp_cnt        = 0;
      exp_gap       = gap;
      SEL_first     = 4'(first);
      SEL_last      = 4'(last);
      repetitions   = 8'(reps);
      inter_run_gap = GAP_WIDTH'(gap);
      start = 1'b1;
      tick();
      start = 1'b0;
      SEL_first     = 4'($urandom);
      SEL_last      = 4'($urandom);
      repetitions   = 8'($urandom);
      inter_run_gap = GAP_WIDTH'($urandom);
   endtask

   task automatic wait_fires(input int n);
      int t = 0;
      while (fire_sel.size() < n && t < 2000) begin
         tick();
         t++;
      end
   endtask

   task automatic wait_done();
      int t = 0;
      while (done_cnt == 0 && t < 5000) begin
         tick();
         t++;
      end
   endtask

   task automatic wait_seq_idle();
      int t = 0;
      while (seq_phase != 0 && t < 5000) begin
         tick();
         t++;
      end
   endtask

   // Full scan checked against the address list the scan rules generate.
   task automatic run_scan(input string tag, input int first, input int last, input int reps,
                           input int gap);
      int exp_q[$];
      bit invalid;
      int lat;
      invalid = (first > last) || (reps == 0);
      if (!invalid) begin
         for (int s = first; s <= last; s++) begin
            for (int r = 0; r < reps; r++) exp_q.push_back(s);
         end
      end
      begin_scan(first, last, reps, gap);
      check_eq({tag, ":busy_after_start"}, busy, 1);
      check_eq({tag, ":error_flag_cleared"}, error_flag, 0);
      check_eq({tag, ":error_code_cleared"}, error_code, 0);
      check_eq({tag, ":run_count_cleared"}, run_count, 0);
      lat = 1;
      while (done_cnt == 0 && lat < 5000) begin
         tick();
         lat++;
      end
      if (invalid) check_eq({tag, ":done_latency"}, lat, 2);
      tick();
      check_eq({tag, ":done_pulses"}, done_cnt, 1);
      check_eq({tag, ":busy_end"}, busy, 0);
      check_eq({tag, ":error_code"}, error_code, invalid ? 1 : 0);
      check_eq({tag, ":error_flag"}, error_flag, invalid ? 1 : 0);
      check_eq({tag, ":run_count"}, run_count, exp_q.size());
      check_eq({tag, ":measure_pulses"}, mp_cnt, exp_q.size());
      check_eq({tag, ":fire_count"}, fire_sel.size(), exp_q.size());
      for (int i = 0; i < exp_q.size(); i++) begin
         if (i < fire_sel.size()) begin
            check_eq($sformatf("%s:sel[%0d]", tag, i), fire_sel[i], exp_q[i]);
         end
      end
   endtask

   initial begin
      #900000;
      $display("FAIL watchdog expired at cycle %0d", cyc);
      $fatal(1);
   end

   initial begin
      int first;
      int last;
      int reps;
      int gap;
      seq_if.ready_flag   = 1'b1;
      seq_if.measure_flag = 1'b0;
      reset         = 1'b1;
      start         = 1'b0;
      abort         = 1'b0;
      SEL_first     = '0;
      SEL_last      = '0;
      repetitions   = '0;
      inter_run_gap = '0;
      tick();
      tick();
      check_outputs_zero("reset_held");
      reset = 1'b0;
      tick();
      check_outputs_zero("reset_released");

      // Single pixel, single run.
      meas_time = 33;
      ack_dly   = 0;
      run_scan("single", 3, 3, 1, 0);

      // Three pixels, two runs each, gap of 4.
      meas_time = 12;
      ack_dly   = 1;
      run_scan("range_3_5", 3, 5, 2, 4);

      // Invalid configurations.
      run_scan("inv_order", 9, 2, 1, 0);
      run_scan("inv_reps0", 4, 6, 0, 3);

      // Top of the address range must terminate without wrapping.
      run_scan("top_edge", 14, 15, 2, 0);

      // Sequencer never acknowledges.
      seq_hold = 1'b1;
      begin_scan(1, 1, 1, 0);
      wait_fires(1);
      wait_done();
      check_eq("ack_tmo:latency_window",
               int'((last_done_cyc - last_fire_cyc) >= int'(TIMEOUT_CYCLES) &&
                    (last_done_cyc - last_fire_cyc) <= int'(TIMEOUT_CYCLES) + 2), 1);
      tick();
      check_eq("ack_tmo:done_pulses", done_cnt, 1);
      check_eq("ack_tmo:error_code", error_code, 2);
      check_eq("ack_tmo:error_flag", error_flag, 1);
      check_eq("ack_tmo:busy", busy, 0);
      check_eq("ack_tmo:fires", fire_sel.size(), 1);
      check_eq("ack_tmo:run_count", run_count, 0);
      seq_hold = 1'b0;
      run_scan("after_ack_tmo", 6, 7, 1, 1);

      // Sequencer acknowledges but never finishes in time.
      meas_time = 1100;
      ack_dly   = 0;
      begin_scan(2, 2, 1, 0);
      wait_done();
      tick();
      check_eq("fin_tmo:error_code", error_code, 3);
      check_eq("fin_tmo:error_flag", error_flag, 1);
      check_eq("fin_tmo:run_count", run_count, 0);
      check_eq("fin_tmo:fires", fire_sel.size(), 1);
      wait_seq_idle();

      // Abort during the second run; a start while busy is ignored.
      meas_time = 12;
      ack_dly   = 1;
      begin_scan(3, 5, 2, 2);
      wait_fires(1);
      tick();
      SEL_first = 4'd7;
      SEL_last  = 4'd7;
      start     = 1'b1;
      tick();
      start = 1'b0;
      wait_fires(2);
      tick();
      tick();
      tick();
      abort = 1'b1;
      tick();
      abort = 1'b0;
      check_eq("abort:busy_next", busy, 0);
      check_eq("abort:run_sequencer", seq_if.run_sequencer, 0);
      for (int i = 0; i < 300; i++) tick();
      check_eq("abort:fires", fire_sel.size(), 2);
      if (fire_sel.size() >= 2) begin
         check_eq("abort:sel0", fire_sel[0], 3);
         check_eq("abort:sel1", fire_sel[1], 3);
      end
      check_eq("abort:done_pulses", done_cnt, 0);
      check_eq("abort:run_count", run_count, 1);
      check_eq("abort:measure_pulses", mp_cnt, 1);
      check_eq("abort:error_code", error_code, 0);
      check_eq("abort:error_flag", error_flag, 0);
      check_eq("abort:busy_late", busy, 0);
      wait_seq_idle();

      // Reset in the middle of a run, then a clean scan.
      meas_time = 20;
      ack_dly   = 0;
      begin_scan(2, 4, 1, 0);
      wait_fires(1);
      tick();
      tick();
      tick();
      reset = 1'b1;
      tick();
      check_outputs_zero("mid_reset");
      reset = 1'b0;
      wait_seq_idle();
      run_scan("after_reset", 2, 4, 1, 0);

      // Randomized scans.
      for (int n = 0; n < 10; n++) begin
         first = $urandom_range(0, 15);
         last  = first + $urandom_range(0, 3);
         if (last > 15) last = 15;
         if ($urandom_range(0, 4) == 0 && first > 0) last = first - 1;
         reps      = $urandom_range(0, 3);
         gap       = $urandom_range(0, 6);
         meas_time = $urandom_range(4, 30);
         ack_dly   = $urandom_range(0, 3);
         run_scan($sformatf("rnd%0d", n), first, last, reps, gap);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
